// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and iteration count for the
// execute-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // One multiplier/quotient bit is consumed per CALC cycle.
  localparam int ITERS = 32;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op[5:2] == OP_MULT[5:2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a HI/LO pair: either as one
// 2*WIDTH value (products) or as two independent halves (quotient/remainder, operands).
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             joint,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2*WIDTH-1:0] pair_neg;

  always_comb begin
    pair_neg = -{hi_in, lo_in};
    hi_out   = hi_in;
    lo_out   = lo_in;
    if (joint) begin
      // In joint mode the product sign rides on neg_lo.
      if (neg_lo) {hi_out, lo_out} = pair_neg;
    end else begin
      if (neg_hi) hi_out = -hi_in;
      if (neg_lo) lo_out = -lo_in;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply (shift-add) / divide (restoring) unit writing
// architectural HI/LO; signed ops work on magnitudes and fix the sign at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [5:0]       Op_Code,
  input  logic [WIDTH-1:0] inpt1,
  input  logic [WIDTH-1:0] inpt2,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(ITERS);

  state_t state, state_next;

  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic               div_p0, sgn_a_p0, sgn_b_p0, zero_p0;
  logic [WIDTH-1:0]   opnd_p0;
  logic [2*WIDTH-1:0] acc_p0, acc_next;

  logic [WIDTH:0]   mul_sum, rem_shift, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign accept    = En && is_muldiv_op(Op_Code);
  assign last_iter = (cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sgn_a = ~Op_Code[0] & inpt1[WIDTH-1];
  assign sgn_b = ~Op_Code[0] & inpt2[WIDTH-1];

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .joint  (1'b0),
    .neg_hi (sgn_a),
    .neg_lo (sgn_b),
    .hi_in  (inpt1),
    .lo_in  (inpt2),
    .hi_out (abs_a),
    .lo_out (abs_b)
  );

  // Accept stage: latch magnitudes, sign flags and op type.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      div_p0   <= Op_Code[1];
      sgn_a_p0 <= sgn_a;
      sgn_b_p0 <= sgn_b;
      zero_p0  <= Op_Code[1] && (inpt2 == '0);
      opnd_p0  <= Op_Code[1] ? abs_b : abs_a;
      acc_p0   <= {{WIDTH{1'b0}}, (Op_Code[1] ? abs_a : abs_b)};
    end else if (state == CALC) begin
      acc_p0 <= acc_next;
    end
  end

  // CALC stage: upper half is partial product / remainder, lower half is
  // multiplier / dividend being shifted out while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + (acc_p0[0] ? {1'b0, opnd_p0} : '0);
    rem_shift = {acc_p0[2*WIDTH-1:WIDTH], acc_p0[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, opnd_p0});
    rem_sub   = rem_shift - {1'b0, opnd_p0};
    if (!div_p0)
      acc_next = {mul_sum, acc_p0[WIDTH-1:1]};
    else if (rem_ge)
      acc_next = {rem_sub[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem_shift[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b0};
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .joint  (~div_p0),
    .neg_hi (sgn_a_p0),
    .neg_lo (sgn_a_p0 ^ sgn_b_p0),
    .hi_in  (acc_p0[2*WIDTH-1:WIDTH]),
    .lo_in  (acc_p0[WIDTH-1:0]),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  // FIX stage: a zero divisor leaves the dividend in HI after 32 always-subtract steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      Done     <= 1'b0;
      Div_Zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      Done <= 1'b0;
      cnt  <= (state == CALC) ? cnt + CNT_W'(1) : '0;
      if (state == FIX) begin
        HI       <= fix_hi;
        LO       <= zero_p0 ? '1 : fix_lo;
        Div_Zero <= zero_p0;
        Done     <= 1'b1;
      end
    end
  end

endmodule
